// File: rtl/dc_fu_pkg.sv
// ---------------------------------------------------------------------------
// dc_fu_pkg
// Shared definitions for the fetching-unit pixel path.
//   pixel_format_t : run-time pixel size selector (bytes per pixel minus 1)
//   BYTE_W         : width of one byte lane
//   fmt_to_bpp()   : converts a pixel format into a byte count (1..4)
// ---------------------------------------------------------------------------
package dc_fu_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      PF_1B = 2'd0,
      PF_2B = 2'd1,
      PF_3B = 2'd2,
      PF_4B = 2'd3
   } pixel_format_t;

   function automatic logic [2:0] fmt_to_bpp(input pixel_format_t fmt);
      return 3'(fmt) + 3'd1;
   endfunction

endpackage

// File: rtl/dc_fu_byte_accum.sv
// ---------------------------------------------------------------------------
// dc_fu_byte_accum
// Shift/append byte buffer. Bytes are kept in arrival order with the oldest
// byte in slot 0. In one cycle the buffer can drop pop_n bytes from the
// bottom and append a whole read beat right behind the surviving bytes.
// Slots above count are always zero.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   en               state update enable (all state holds when low)
//   flush            empty the buffer (priority over push/pop)
//   push, push_data  append READ_BYTES bytes (byte 0 = earliest)
//   pop, pop_n       remove pop_n bytes from the bottom
//   count            number of valid bytes held
//   head             lowest MAX_BPP bytes of the buffer
// ---------------------------------------------------------------------------
module dc_fu_byte_accum
   import dc_fu_pkg::*;
#(
   parameter int unsigned READ_BYTES = 2,
   parameter int unsigned MAX_BPP    = 4,
   localparam int unsigned CAP       = READ_BYTES + MAX_BPP - 1,
   localparam int unsigned CW        = $clog2(CAP + 1)
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         push,
   input  logic [READ_BYTES*BYTE_W-1:0] push_data,
   input  logic                         pop,
   input  logic [CW-1:0]                pop_n,
   output logic [CW-1:0]                count,
   output logic [MAX_BPP*BYTE_W-1:0]    head
);

   logic [BYTE_W-1:0] r_buf [CAP];
   logic [CW-1:0]     r_count;

   logic [BYTE_W-1:0] w_buf_next [CAP];
   logic [CW-1:0]     w_pop_n;
   logic [CW-1:0]     w_base;
   logic [CW-1:0]     w_count_next;

   // w_base is the count after the pop: the slot where the new beat lands.
   assign w_pop_n      = pop ? pop_n : '0;
   assign w_base       = r_count - w_pop_n;
   assign w_count_next = w_base + (push ? CW'(READ_BYTES) : '0);

   genvar gi;
   generate
      for (gi = 0; gi < CAP; gi++) begin : g_slot
         logic [BYTE_W-1:0] w_shift;
         logic [BYTE_W-1:0] w_slot;

         // Slot gi receives the byte that was pop_n slots higher, or zero
         // when that source lies beyond the top of the buffer.
         always_comb begin
            w_shift = '0;
            for (int s = 0; s < CAP; s++) begin
               if (s == gi + int'(w_pop_n)) w_shift = r_buf[s];
            end
         end

         // Incoming beat bytes overwrite the post-shift image from w_base up.
         always_comb begin
            w_slot = w_shift;
            for (int p = 0; p < READ_BYTES; p++) begin
               if (push && (gi == int'(w_base) + p))
                  w_slot = push_data[p*BYTE_W +: BYTE_W];
            end
         end

         assign w_buf_next[gi] = w_slot;
      end

      for (gi = 0; gi < MAX_BPP; gi++) begin : g_head
         assign head[gi*BYTE_W +: BYTE_W] = r_buf[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_count <= '0;
         for (int i = 0; i < CAP; i++) r_buf[i] <= '0;
      end else if (en) begin
         if (flush) begin
            r_count <= '0;
            for (int i = 0; i < CAP; i++) r_buf[i] <= '0;
         end else if (push || pop) begin
            r_count <= w_count_next;
            for (int i = 0; i < CAP; i++) r_buf[i] <= w_buf_next[i];
         end
      end
   end

   assign count = r_count;

endmodule

// File: rtl/dc_fu_pixel_unpack_gen.sv
// ---------------------------------------------------------------------------
// dc_fu_pixel_unpack_gen
// Turns AXI read beats of 2^READ_DATA_SIZE bytes into whole pixels of 1..4
// bytes (size chosen at run time) and pushes them into the pixel FIFO.
// Optional build macro: DC_FU_UNPACK_ERR_EN adds the sticky residual_err
// output, set when a flush discards a partial pixel.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   en                   global enable; low freezes everything
//   fetch_in_progress    low = flush the byte buffer and output register
//   pixel_format         bytes per pixel minus 1
//   axi_rvalid/rdata     read beat in (little-endian)
//   axi_rready           beat accept, from registered state only
//   pixel_valid/ready    pixel handshake towards the FIFO
//   pixel_data           pixel, zero-extended above the active byte count
//   residual_err         (DC_FU_UNPACK_ERR_EN only) sticky residual flag
// ---------------------------------------------------------------------------
module dc_fu_pixel_unpack_gen
   import dc_fu_pkg::*;
#(
   parameter int unsigned READ_DATA_SIZE      = 1,
   parameter int unsigned MAX_BYTES_PER_PIXEL = 4,
   localparam int unsigned READ_BYTES         = 1 << READ_DATA_SIZE,
   localparam int unsigned PIX_W              = MAX_BYTES_PER_PIXEL * BYTE_W
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         en,
   input  logic                         fetch_in_progress,
   input  logic [1:0]                   pixel_format,
   input  logic                         axi_rvalid,
   input  logic [READ_BYTES*BYTE_W-1:0] axi_rdata,
   output logic                         axi_rready,
   output logic                         pixel_valid,
   input  logic                         pixel_ready,
   output logic [PIX_W-1:0]             pixel_data
`ifdef DC_FU_UNPACK_ERR_EN
   ,
   output logic                         residual_err
`endif
);

   localparam int unsigned CAP = READ_BYTES + MAX_BYTES_PER_PIXEL - 1;
   localparam int unsigned CW  = $clog2(CAP + 1);

   pixel_format_t    w_fmt;
   logic [CW-1:0]    w_bpp;
   logic [CW-1:0]    w_count;
   logic [PIX_W-1:0] w_head;
   logic [PIX_W-1:0] w_pix_next;
   logic             w_room;
   logic             w_push;
   logic             w_load;

   logic             r_active;
   logic             r_pixel_valid;
   logic [PIX_W-1:0] r_pixel_data;

   assign w_fmt = pixel_format_t'(pixel_format);
   assign w_bpp = CW'(fmt_to_bpp(w_fmt));

   // One extra bit so count + READ_BYTES cannot wrap.
   assign w_room = ({1'b0, w_count} + (CW+1)'(READ_BYTES)) <= (CW+1)'(CAP);

   // r_active keeps rready low while nrst is asserted, even though the
   // empty buffer would otherwise report room.
   assign axi_rready = r_active & en & fetch_in_progress & w_room;
   assign w_push     = axi_rvalid & axi_rready;
   assign w_load     = en & fetch_in_progress & (~r_pixel_valid | pixel_ready)
                       & (w_count >= w_bpp);

   dc_fu_byte_accum #(
      .READ_BYTES (READ_BYTES),
      .MAX_BPP    (MAX_BYTES_PER_PIXEL)
   ) u_accum (
      .clk       (clk),
      .nrst      (nrst),
      .en        (en),
      .flush     (~fetch_in_progress),
      .push      (w_push),
      .push_data (axi_rdata),
      .pop       (w_load),
      .pop_n     (w_bpp),
      .count     (w_count),
      .head      (w_head)
   );

   // Keep only the active pixel bytes; upper lanes read as zero.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_BYTES_PER_PIXEL; gi++) begin : g_pix
         assign w_pix_next[gi*BYTE_W +: BYTE_W] =
            (gi < int'(w_bpp)) ? w_head[gi*BYTE_W +: BYTE_W] : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_active      <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_pixel_data  <= '0;
      end else begin
         r_active <= 1'b1;
         if (en) begin
            if (!fetch_in_progress) begin
               r_pixel_valid <= 1'b0;
               r_pixel_data  <= '0;
            end else if (w_load) begin
               r_pixel_valid <= 1'b1;
               r_pixel_data  <= w_pix_next;
            end else if (pixel_ready && r_pixel_valid) begin
               r_pixel_valid <= 1'b0;
            end
         end
      end
   end

   assign pixel_valid = r_pixel_valid;
   assign pixel_data  = r_pixel_data;

`ifdef DC_FU_UNPACK_ERR_EN
   logic r_residual_err;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_residual_err <= 1'b0;
      end else if (en && !fetch_in_progress && (w_count != '0)) begin
         r_residual_err <= 1'b1;
      end
   end

   assign residual_err = r_residual_err;
`endif

   // The pixel size may only change while the buffer is empty.
   a_fmt_stable: assert property (@(posedge clk) disable iff (!nrst)
      (en && fetch_in_progress && (w_count != '0)) |=> $stable(pixel_format));

endmodule
